// File: rtl/load_store_unit.sv
// RV32I load/store unit: sizes, aligns and lane-replicates core memory requests,
// waits for mem_ack with a bounded timeout, and extends the returned lane.
module load_store_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        fault,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        err_q, err_nxt;
    logic        st_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] rword_q;
    logic [7:0]  cnt_q;

    function automatic logic req_legal(input logic st, input logic [2:0] f3);
        if (st)
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else
            return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                   (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    function automatic logic req_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic st, input logic [2:0] f3,
                                           input logic [1:0] off);
        if (!st)
            return 4'b1111;
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Halfword lane uses off[1] only; alignment was enforced at accept.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] w);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  bs;
        logic signed [15:0] hs;
        b  = 8'(w >> {off, 3'b000});
        h  = off[1] ? w[31:16] : w[15:0];
        bs = b;
        hs = h;
        case (f3)
            3'b000:  return 32'(bs);
            3'b001:  return 32'(hs);
            3'b010:  return w;
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return 32'd0;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        case (state)
            IDLE: begin
                if (valid) begin
                    if (req_legal(is_store, funct3) && !req_misaligned(funct3, addr[1:0])) begin
                        state_nxt = BUSY;
                        err_nxt   = 1'b0;
                    end else begin
                        state_nxt = RESP;
                        err_nxt   = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_nxt = RESP;
                    err_nxt   = 1'b0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_nxt = RESP;
                    err_nxt   = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            err_q     <= 1'b0;
            st_q      <= 1'b0;
            we_q      <= 1'b0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            rword_q   <= 32'd0;
            cnt_q     <= 8'd0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'b0000;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
            if (state == IDLE && valid) begin
                st_q      <= is_store;
                we_q      <= is_store;
                f3_q      <= funct3;
                off_q     <= addr[1:0];
                mem_addr  <= {addr[31:2], 2'b00};
                mem_wdata <= replicate(funct3, wdata);
                mem_be    <= byte_en(is_store, funct3, addr[1:0]);
                cnt_q     <= 8'd0;
            end else if (state == BUSY) begin
                cnt_q <= cnt_q + 8'd1;
                if (mem_ack)
                    rword_q <= mem_rdata;
            end
        end
    end

    // Outputs decode from state so an async reset drops mem_req at once.
    assign mem_req = (state == BUSY);
    assign mem_we  = (state == BUSY) && we_q;
    assign done    = (state == RESP) && !err_q;
    assign fault   = (state == RESP) && err_q;
    assign rdata   = (done && !st_q) ? load_extend(f3_q, off_q, rword_q) : 32'd0;
    assign stall   = valid && (state != RESP);

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a behavioural memory
// responder and an arithmetic reference model of the RV32I access rules.
module tb_load_store_unit;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        fault;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .valid(valid), .is_store(is_store),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
        .done(done), .fault(fault), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        int          len;
    } mem_exp_t;

    typedef struct {
        logic        done;
        logic        fault;
        logic [31:0] rdata;
        int          cyc;
    } resp_exp_t;

    mem_exp_t  mem_q[$];
    resp_exp_t resp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_cnt  = 0;

    int          ack_delay = 1;
    logic [31:0] rword     = 32'd0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: expected bus request and response for one access.
    function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rw, input int d,
                                  output logic ok, output mem_exp_t m, output resp_exp_t r);
        int          size;
        int          sh;
        logic        legal;
        logic        mis;
        logic [31:0] mask;
        logic [31:0] v;
        size  = int'(f3[1:0]);
        sh    = 8 * int'(a[1:0]);
        legal = st ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        mis   = (size == 1 && a[0]) || (size == 2 && a[1:0] != 2'b00);
        ok    = legal && !mis;

        m.addr = a & 32'hFFFF_FFFC;
        m.we   = st;
        if (!st || size >= 2) m.be = 4'hF;
        else if (size == 0)   m.be = 4'(1 << a[1:0]);
        else                  m.be = 4'(3 << a[1:0]);
        if (size == 0)      m.wdata = wd[7:0] * 32'h0101_0101;
        else if (size == 1) m.wdata = wd[15:0] * 32'h0001_0001;
        else                m.wdata = wd;
        m.len = !ok ? 0 : (d > TIMEOUT ? TIMEOUT : d);

        r.fault = !ok || d > TIMEOUT;
        r.done  = !r.fault;
        r.rdata = 32'd0;
        r.cyc   = 0;
        if (r.done && !st) begin
            if (size == 2) begin
                r.rdata = rw;
            end else begin
                mask = (size == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
                v    = (rw >> sh) & mask;
                if (!f3[2] && v > (mask >> 1))
                    v = v - mask - 32'd1;
                r.rdata = v;
            end
        end
    endfunction

    task automatic wait_resp();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done || fault) return;
        end
        n_checks++;
        $display("FAIL resp_wait: no done/fault within 400 cycles (t=%0t)", $time);
    endtask

    // Called at a falling edge while the DUT is in IDLE.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rw, input int d);
        logic      ok;
        mem_exp_t  m;
        resp_exp_t r;
        model(st, f3, a, wd, rw, d, ok, m, r);
        r.cyc = cyc_cnt + 1 + m.len;
        if (ok) mem_q.push_back(m);
        resp_q.push_back(r);
        ack_delay = d;
        rword     = rw;
        is_store  = st;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        valid     = 1'b1;
        wait_resp();
    endtask

    // Memory responder: acks in the d-th BUSY cycle, garbage data otherwise.
    initial begin
        int busy_n;
        busy_n    = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                busy_n++;
                mem_ack   = (busy_n == ack_delay);
                mem_rdata = mem_ack ? rword : $urandom;
            end else begin
                busy_n    = 0;
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    // Monitor: checks bus requests and responses against the scoreboard.
    initial begin
        mem_exp_t  cur;
        resp_exp_t e;
        int        req_len;
        logic      req_prev;
        req_len  = 0;
        req_prev = 1'b0;
        cur      = '{default: 0};
        forever begin
            @(negedge clk);
            if (mem_req && !req_prev) begin
                if (mem_q.size() == 0) begin
                    check("unexpected_mem_req", mem_req, 1'b0);
                end else begin
                    cur = mem_q.pop_front();
                    check("mem_addr", mem_addr, cur.addr);
                    check("mem_we", mem_we, cur.we);
                    check("mem_be", mem_be, cur.be);
                    check("mem_wdata", mem_wdata, cur.wdata);
                    check("stall_busy", stall, 1'b1);
                end
                req_len = 1;
            end else if (mem_req) begin
                req_len++;
                check("mem_addr_hold", mem_addr, cur.addr);
                check("mem_be_hold", mem_be, cur.be);
            end
            if (!mem_req && req_prev)
                check("busy_len", req_len, cur.len);
            req_prev = mem_req;

            if (done || fault) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_resp", {30'd0, done, fault}, 32'd0);
                end else begin
                    e = resp_q.pop_front();
                    check("done", done, e.done);
                    check("fault", fault, e.fault);
                    check("rdata", rdata, e.rdata);
                    check("latency_cycle", cyc_cnt, e.cyc);
                    check("stall_resp", stall, 1'b0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic      ok;
        mem_exp_t  m;
        resp_exp_t r;
        logic [2:0]  f3;
        logic [31:0] a;
        int          d;

        reset    = 1'b1;
        valid    = 1'b0;
        is_store = 1'b0;
        funct3   = 3'd0;
        addr     = 32'd0;
        wdata    = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_mem_be", mem_be, 4'b0000);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_stall", stall, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        issue(1'b1, 3'b010, 32'h64, 32'h19, $urandom, 1);
        @(negedge clk); issue(1'b0, 3'b000, 32'h3, 32'd0, 32'h80FF_FFFF, 1);
        @(negedge clk); issue(1'b0, 3'b100, 32'h3, 32'd0, 32'h80FF_FFFF, 2);
        @(negedge clk); issue(1'b1, 3'b001, 32'h22, 32'h1234_ABCD, $urandom, 1);
        @(negedge clk); issue(1'b0, 3'b010, 32'h6, 32'd0, $urandom, 1);
        @(negedge clk); issue(1'b0, 3'b011, 32'h8, 32'd0, $urandom, 1);
        @(negedge clk); issue(1'b1, 3'b100, 32'h8, 32'hDEAD_BEEF, $urandom, 1);
        @(negedge clk); issue(1'b0, 3'b101, 32'h1002, 32'd0, 32'h8001_7F02, 3);
        @(negedge clk); issue(1'b0, 3'b010, 32'h100, 32'd0, $urandom, 255);
        @(negedge clk); issue(1'b0, 3'b010, 32'h104, 32'd0, 32'hCAFE_F00D, TIMEOUT);

        // Abandon a load with reset in its third BUSY cycle.
        @(negedge clk);
        model(1'b0, 3'b010, 32'h200, 32'd0, 32'd0, 255, ok, m, r);
        m.len = 3;
        mem_q.push_back(m);
        ack_delay = 255;
        is_store  = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h200;
        valid     = 1'b1;
        for (int i = 0; i < 10 && !mem_req; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_busy_mem_req", mem_req, 1'b0);
        check("rst_busy_done", done, 1'b0);
        check("rst_busy_fault", fault, 1'b0);
        check("rst_busy_mem_addr", mem_addr, 32'd0);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        issue(1'b0, 3'b001, 32'h42, 32'd0, 32'h1234_8765, 3);

        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 : {a[1], 1'b0};
            d  = ($urandom_range(0, 9) == 0) ? TIMEOUT + $urandom_range(0, 3) : $urandom_range(1, 6);
            issue(1'($urandom_range(0, 1)), f3, a, $urandom, $urandom, d);
        end

        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mem_q_drained", mem_q.size(), 32'd0);
        check("resp_q_drained", resp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of BUSY cycles to wait for mem_ack before faulting (range 1..255).
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port valid, input, 1, core requests a memory operation.
REQ-005 SHALL have port is_store, input, 1, 1 = store, 0 = load.
REQ-006 SHALL have port funct3, input, 3, access size/sign per RV32I load/store encoding.
REQ-007 SHALL have port addr, input, 32, byte address (ALU result).
REQ-008 SHALL have port wdata, input, 32, store data (rs2).
REQ-009 SHALL have port rdata, output, 32, extended load result; meaningful only while done=1.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port fault, output, 1, one-cycle error pulse (misaligned, illegal funct3, timeout).
REQ-012 SHALL have port stall, output, 1, core must hold PC and inputs.
REQ-013 SHALL have port mem_req, output, 1, memory request.
REQ-014 SHALL have port mem_we, output, 1, write enable.
REQ-015 SHALL have port mem_addr, output, 32, word address {addr[31:2],2'b00}.
REQ-016 SHALL have port mem_wdata, output, 32, lane-replicated store data.
REQ-017 SHALL have port mem_be, output, 4, byte enables.
REQ-018 SHALL have port mem_rdata, input, 32, memory read word.
REQ-019 SHALL have port mem_ack, input, 1, memory completion, valid only while mem_req=1.

Function
REQ-020 SHALL implement FSM states IDLE, BUSY, RESP; IDLE->BUSY on valid with a legal, aligned request; IDLE->RESP with fault on an illegal or misaligned request; BUSY->RESP on mem_ack or timeout; RESP->IDLE unconditionally.
REQ-021 SHALL accept a request only in IDLE with valid=1, latching is_store, funct3, addr[1:0], wdata and word address.
REQ-022 SHALL treat funct3 as legal for loads in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU} and for stores in {000 SB, 001 SH, 010 SW}; all other codes are illegal.
REQ-023 SHALL treat halfword access with addr[0]=1 and word access with addr[1:0]!=0 as misaligned; no mem_req is issued.
REQ-024 SHALL drive mem_req=1 throughout BUSY only, with mem_addr, mem_we, mem_be and mem_wdata held stable from registered values.
REQ-025 SHALL generate mem_be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111; loads 4'b1111.
REQ-026 SHALL replicate store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
REQ-027 SHALL register mem_rdata on the mem_ack edge and, in RESP, present rdata as the lane selected by addr[1:0]: byte/halfword sign-extended (LB, LH), zero-extended (LBU, LHU), or the full word (LW); rdata=0 for stores and faults.
REQ-028 SHALL count BUSY cycles in an 8-bit counter cleared on entry; when the count reaches TIMEOUT without mem_ack, the FSM enters RESP with fault=1.
REQ-029 SHALL assert done=1 in RESP only for a successful operation, and fault=1 in RESP only for an error; the two are never both 1.
REQ-030 SHALL drive stall = valid & ~(state==RESP), combinationally.
REQ-031 SHALL ignore valid in RESP and BUSY; a back-to-back request is accepted in the IDLE cycle that follows RESP.
REQ-032 SHALL give a minimum latency of accept edge -> BUSY (1 cycle, mem_ack same cycle) -> RESP, i.e. done is asserted 2 cycles after the accept cycle.
REQ-033 SHALL ignore mem_ack outside BUSY.

Reset
REQ-034 SHALL on reset asynchronously force IDLE and set mem_req, mem_we, done and fault to 0, mem_be to 4'b0000, rdata, mem_addr and mem_wdata to 0, and the counter to 0.
REQ-035 SHALL abandon an in-flight request on reset, dropping mem_req in the same cycle; no done or fault is generated for it.

Verification
REQ-036 SHALL be verified with SW addr=0x64, wdata=0x19, ack after 1 cycle -> mem_be=1111, mem_addr=0x64, mem_wdata=0x19, done 2 cycles after accept.
REQ-037 SHALL be verified with LB addr=0x03, mem_rdata=0x80FF_FF_FF -> rdata=0xFFFFFF80; and LBU from the same address -> rdata=0x00000080.
REQ-038 SHALL be verified with SH addr=0x22, wdata=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x20.
REQ-039 SHALL be verified with LW addr=0x06 -> no mem_req, fault=1 one cycle later, rdata=0.
REQ-040 SHALL be verified with TIMEOUT=15, LW and mem_ack held low -> mem_req high for 15 cycles, then fault=1, then IDLE.
REQ-041 SHALL be verified with reset asserted in the 3rd BUSY cycle -> mem_req=0 immediately, no done, and the next request completes normally.
